// File: rtl/gpio_conf_master_pkg.sv
// Shared definitions for the GPIO configuration initiator: default widths,
// FSM state encoding, channel select codes and the timeout timer width helper.
package gpio_conf_master_pkg;

    localparam int unsigned C0_W_DEF    = 24;
    localparam int unsigned C1_W_DEF    = 17;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Timer must hold 0..TIMEOUT; a disabled timeout still needs one bit.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gpio_conf_master_chan_drv.sv
// One initiator channel of the configuration handshake.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   load_i, data_i    : start a write with data_i (raises valid)
//   done_i            : transfer happened; drop valid, capture shadow
//   abort_i           : timeout; drop valid, keep shadow
//   ready_i           : responder ready
//   valid_o, data_o   : channel valid/data toward the responder
//   shadow_o          : last successfully transferred word
//   xfer_o            : valid & ready (combinational)
module gpio_conf_master_chan_drv #(
    parameter int unsigned W = 24
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         done_i,
    input  logic         abort_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [W-1:0] shadow_o,
    output logic         xfer_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic [W-1:0] shadow_q;

    // Data only changes on load, so it stays stable while valid is high
    // and keeps its last value after valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            shadow_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (done_i) begin
            valid_q  <= 1'b0;
            shadow_q <= data_q;
        end else if (abort_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign shadow_o = shadow_q;
    assign xfer_o   = valid_q & ready_i;

endmodule

// File: rtl/gpio_conf_master.sv
// Initiator of the GPIO configuration handshake: takes one host write command
// at a time and drives it onto channel 0 or channel 1, with timeout abort and
// shadow copies of the last successfully written words.
// Ports:
//   clock, reset                 : clock and synchronous active-high reset
//   cmd_valid/cmd_ready          : host command handshake (ready only in IDLE)
//   cmd_sel, cmd_data            : target channel and write data
//   rsp_valid, rsp_err           : one-cycle completion pulse, err = timeout
//   busy                         : a command is in flight
//   conf_0_* / conf_1_*          : valid/ready/data toward the responder
//   shadow_0, shadow_1           : last successfully transferred words
module gpio_conf_master
    import gpio_conf_master_pkg::*;
#(
    parameter int unsigned C0_W    = C0_W_DEF,
    parameter int unsigned C1_W    = C1_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_sel,
    input  logic [C0_W-1:0] cmd_data,
    output logic            rsp_valid,
    output logic            rsp_err,
    output logic            busy,
    output logic            conf_0_valid,
    input  logic            conf_0_ready,
    output logic [C0_W-1:0] conf_0_data,
    output logic            conf_1_valid,
    input  logic            conf_1_ready,
    output logic [C1_W-1:0] conf_1_data,
    output logic [C0_W-1:0] shadow_0,
    output logic [C1_W-1:0] shadow_1
);

    localparam int unsigned      TO_W    = timer_width(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic            sel_q;
    logic [TO_W-1:0] timer_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;

    logic accept, in_send, timeout_hit;
    logic xfer0, xfer1, xfer_sel;
    logic load0, load1, done0, done1, abort0, abort1;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SEND);
    assign accept      = cmd_ready && cmd_valid;
    assign in_send     = busy;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);
    assign xfer_sel    = (sel_q == CH0) ? xfer0 : xfer1;

    // Per-channel controls; the unselected channel never sees load/done/abort.
    assign load0  = accept && (cmd_sel == CH0);
    assign load1  = accept && (cmd_sel == CH1);
    assign done0  = in_send && (sel_q == CH0) && xfer0;
    assign done1  = in_send && (sel_q == CH1) && xfer1;
    assign abort0 = in_send && (sel_q == CH0) && !xfer0 && timeout_hit;
    assign abort1 = in_send && (sel_q == CH1) && !xfer1 && timeout_hit;

    // FSM, shared timer and response registers. Transfer beats timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= CH0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sel_q   <= cmd_sel;
                        timer_q <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (xfer_sel) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TO_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    gpio_conf_master_chan_drv #(.W(C0_W)) u_ch0 (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load0),
        .data_i   (cmd_data),
        .done_i   (done0),
        .abort_i  (abort0),
        .ready_i  (conf_0_ready),
        .valid_o  (conf_0_valid),
        .data_o   (conf_0_data),
        .shadow_o (shadow_0),
        .xfer_o   (xfer0)
    );

    gpio_conf_master_chan_drv #(.W(C1_W)) u_ch1 (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load1),
        .data_i   (cmd_data[C1_W-1:0]),
        .done_i   (done1),
        .abort_i  (abort1),
        .ready_i  (conf_1_ready),
        .valid_o  (conf_1_valid),
        .data_o   (conf_1_data),
        .shadow_o (shadow_1),
        .xfer_o   (xfer1)
    );

endmodule
